// File: rtl/raybox_input_pkg.sv
// raybox_input_pkg: button channel map and debounce timing defaults for the 25 MHz raybox clock
package raybox_input_pkg;
    localparam int BTN_MOVE_F   = 0;
    localparam int BTN_MOVE_B   = 1;
    localparam int BTN_MOVE_L   = 2;
    localparam int BTN_MOVE_R   = 3;
    localparam int BTN_SHOW_MAP = 4;
    localparam int BTN_SPARE    = 5;
    localparam int NUM_BTNS_DEFAULT     = 6;
    localparam int TICK_DIV_DEFAULT     = 25000;
    localparam int STABLE_TICKS_DEFAULT = 10;
    function automatic int min1_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: synchronise, normalise and debounce one button, emitting level and press/release pulses
module debounce_channel
    import raybox_input_pkg::*;
#(
    parameter int STABLE_TICKS = STABLE_TICKS_DEFAULT,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    input  logic tick,
    output logic level,
    output logic press,
    output logic rel
);
    localparam int   CW   = min1_clog2(STABLE_TICKS);
    localparam logic INV  = (ACTIVE_LOW != 0);
    localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);
    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          s;
    assign s = sync[1] ^ INV;
    // any sample matching the current level restarts qualification
    always_ff @(posedge clk) begin
        if (reset) begin
            sync  <= {2{INV}};
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            sync  <= {sync[0], pin};
            press <= 1'b0;
            rel   <= 1'b0;
            if (s == level)
                cnt <= '0;
            else if (tick && cnt == LAST) begin
                level <= s;
                cnt   <= '0;
                press <= s;
                rel   <= ~s;
            end else if (tick)
                cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: rtl/button_debounce.sv
// button_debounce: shared sample-tick prescaler feeding one debounce_channel per raw button pin
module button_debounce
    import raybox_input_pkg::*;
#(
    parameter int NUM_BTNS     = NUM_BTNS_DEFAULT,
    parameter int TICK_DIV     = TICK_DIV_DEFAULT,
    parameter int STABLE_TICKS = STABLE_TICKS_DEFAULT,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_BTNS-1:0] btn_raw,
    output logic [NUM_BTNS-1:0] btn_level,
    output logic [NUM_BTNS-1:0] btn_press,
    output logic [NUM_BTNS-1:0] btn_release,
    output logic                tick
);
    localparam int DW = min1_clog2(TICK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
    logic [DW-1:0] div;
    always_ff @(posedge clk) begin
        if (reset) begin
            div  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (div == DIV_LAST);
            div  <= (div == DIV_LAST) ? '0 : div + DW'(1);
        end
    end
    for (genvar g = 0; g < NUM_BTNS; g++) begin : g_ch
        debounce_channel #(
            .STABLE_TICKS(STABLE_TICKS),
            .ACTIVE_LOW  (ACTIVE_LOW)
        ) u_ch (
            .clk  (clk),
            .reset(reset),
            .pin  (btn_raw[g]),
            .tick (tick),
            .level(btn_level[g]),
            .press(btn_press[g]),
            .rel  (btn_release[g])
        );
    end
endmodule
